// File: rtl/multicycle_controller_if.sv
// Instruction/data memory handshake bundle.
interface multicycle_controller_if #(
  parameter int IW = 19
);
  logic [IW-1:0] instr;
  logic          imem_req;
  logic          imem_ack;
  logic          mem_read;
  logic          mem_write;
  logic          mem_ack;

  modport master (
    output imem_req, mem_read, mem_write,
    input  instr, imem_ack, mem_ack
  );

  modport slave (
    input  imem_req, mem_read, mem_write,
    output instr, imem_ack, mem_ack
  );
endinterface

// File: rtl/multicycle_controller.sv
// Multi-cycle control FSM: FETCH/DECODE/EXEC/MEM/WB/HALT.
// Define CTRL_MEM_TIMEOUT_EN to abort stalled data-memory accesses.
module multicycle_controller #(
  parameter int IW           = 19,
  parameter int MEM_WAIT_MAX = 15
) (
  input  logic                   clock,
  input  logic                   rst,
  multicycle_controller_if.master bus,
  input  logic                   alu_zero,
  input  logic                   alu_carry,
  output logic [IW-1:0]          ir,
  output logic [2:0]             alu_fn,
  output logic [1:0]             shro_fn,
  output logic                   sel_alu_arg,
  output logic                   sel_r2,
  output logic [1:0]             sel_to_write,
  output logic                   reg_write,
  output logic                   pc_en,
  output logic                   pc_sel_jump,
  output logic                   Zero,
  output logic                   Carry,
  output logic                   halted,
  output logic                   err
);
  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC,
    S_MEM, S_WB, S_HALT
  } state_t;

  typedef enum logic [3:0] {
    OP_ALU, OP_SHR, OP_LDM, OP_STM,
    OP_JMP, OP_BZ, OP_BC, OP_NOP,
    OP_HALT
  } op_t;

  state_t     state, next;
  op_t        op;
  logic [1:0] cls;
  logic [2:0] sub;
  logic       iack, mack;
  logic       ir_load, flag_load;
  logic       timeout;
  logic       imem_req, mem_read, mem_write;

  assign cls     = ir[IW-1:IW-2];
  assign sub     = ir[IW-3:IW-5];
  assign alu_fn  = sub;
  assign shro_fn = ir[IW-4:IW-5];
  assign halted  = (state == S_HALT);

  // rst wins over an ack arriving in the same cycle
  assign iack = bus.imem_ack & ~rst;
  assign mack = bus.mem_ack & ~rst;

  assign bus.imem_req  = imem_req;
  assign bus.mem_read  = mem_read;
  assign bus.mem_write = mem_write;

  always_comb begin
    op = OP_NOP;
    unique case (1'b1)
      !cls[1]:                      op = OP_ALU;
      cls == 2'b11 && !sub[2]:      op = OP_SHR;
      cls == 2'b11 && sub[2]:       op = OP_HALT;
      cls == 2'b10 && sub == 3'd0:  op = OP_LDM;
      cls == 2'b10 && sub == 3'd1:  op = OP_STM;
      cls == 2'b10 && sub == 3'd4:  op = OP_JMP;
      cls == 2'b10 && sub == 3'd5:  op = OP_BZ;
      cls == 2'b10 && sub == 3'd6:  op = OP_BC;
      default:                      op = OP_NOP;
    endcase
  end

`ifdef CTRL_MEM_TIMEOUT_EN
  localparam int CW = $clog2(MEM_WAIT_MAX + 1);
  logic [CW-1:0] wait_cnt;

  assign timeout = (state == S_MEM) && !bus.mem_ack
                && !rst && (wait_cnt == CW'(MEM_WAIT_MAX));

  always_ff @(posedge clock) begin
    if (rst) begin
      wait_cnt <= '0;
      err      <= 1'b0;
    end else begin
      if (state == S_EXEC)
        wait_cnt <= '0;
      else if (state == S_MEM && !bus.mem_ack)
        wait_cnt <= wait_cnt + 1'b1;
      if (timeout)
        err <= 1'b1;
    end
  end
`else
  assign timeout = 1'b0;
  assign err     = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (rst) begin
      state <= S_FETCH;
      ir    <= '0;
      Zero  <= 1'b0;
      Carry <= 1'b0;
    end else begin
      state <= next;
      if (ir_load)
        ir <= bus.instr;
      if (flag_load) begin
        Zero  <= alu_zero;
        Carry <= alu_carry;
      end
    end
  end

  always_comb begin
    next         = state;
    imem_req     = 1'b0;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    reg_write    = 1'b0;
    pc_en        = 1'b0;
    pc_sel_jump  = 1'b0;
    sel_alu_arg  = 1'b1;
    sel_r2       = 1'b1;
    sel_to_write = 2'b00;
    ir_load      = 1'b0;
    flag_load    = 1'b0;
    case (state)
      S_FETCH: begin
        imem_req = 1'b1;
        if (iack) begin
          ir_load = 1'b1;
          next    = S_DECODE;
        end
      end
      S_DECODE: next = S_EXEC;
      S_EXEC: begin
        next = S_FETCH;
        case (op)
          OP_ALU: begin
            reg_write   = 1'b1;
            sel_alu_arg = ~ir[IW-2];
            flag_load   = 1'b1;
            pc_en       = 1'b1;
          end
          OP_SHR: begin
            reg_write    = 1'b1;
            sel_to_write = 2'b01;
            pc_en        = 1'b1;
          end
          OP_JMP: begin
            pc_en       = 1'b1;
            pc_sel_jump = 1'b1;
          end
          OP_BZ: begin
            pc_en       = 1'b1;
            pc_sel_jump = Zero;
          end
          OP_BC: begin
            pc_en       = 1'b1;
            pc_sel_jump = Carry;
          end
          OP_LDM, OP_STM: next = S_MEM;
          OP_HALT:        next = S_HALT;
          default:        pc_en = 1'b1;
        endcase
      end
      S_MEM: begin
        if (timeout) begin
          pc_en = 1'b1;
          next  = S_FETCH;
        end else if (op == OP_LDM) begin
          mem_read = 1'b1;
          if (mack)
            next = S_WB;
        end else begin
          mem_write = 1'b1;
          sel_r2    = 1'b0;
          if (mack) begin
            pc_en = 1'b1;
            next  = S_FETCH;
          end
        end
      end
      S_WB: begin
        reg_write    = 1'b1;
        sel_to_write = 2'b10;
        pc_en        = 1'b1;
        next         = S_FETCH;
      end
      S_HALT: next = S_HALT;
      default: next = S_FETCH;
    endcase
  end
endmodule

// File: tb/tb_multicycle_controller.sv
// Directed scoreboard bench for multicycle_controller.
// Build with CTRL_MEM_TIMEOUT_EN to cover the memory-timeout abort.
module tb_multicycle_controller;
  localparam int IW = 19;

  logic          clock = 1'b0;
  logic          rst;
  logic          alu_zero, alu_carry;
  logic [IW-1:0] ir;
  logic [2:0]    alu_fn;
  logic [1:0]    shro_fn, sel_to_write;
  logic          sel_alu_arg, sel_r2;
  logic          reg_write, pc_en, pc_sel_jump;
  logic          Zero, Carry, halted, err;

  int n_cmp = 0;
  int n_bad = 0;
  logic [11:0] exp_q[$];
  string       tag_q[$];
  logic        e_err = 1'b0;

  multicycle_controller_if #(.IW(IW)) bus ();

  multicycle_controller #(
    .IW(IW),
    .MEM_WAIT_MAX(4)
  ) dut (
    .clock(clock),
    .rst(rst),
    .bus(bus),
    .alu_zero(alu_zero),
    .alu_carry(alu_carry),
    .ir(ir),
    .alu_fn(alu_fn),
    .shro_fn(shro_fn),
    .sel_alu_arg(sel_alu_arg),
    .sel_r2(sel_r2),
    .sel_to_write(sel_to_write),
    .reg_write(reg_write),
    .pc_en(pc_en),
    .pc_sel_jump(pc_sel_jump),
    .Zero(Zero),
    .Carry(Carry),
    .halted(halted),
    .err(err)
  );

  always #5 clock = ~clock;

  // {req,rw,mr,mw,pe,pj,stw[1:0],saa,sr2,halted,err}
  function automatic logic [11:0] mk(
    input logic req, rw, mr, mw, pe, pj,
    input logic [1:0] stw,
    input logic saa, sr2, h, e);
    return {req, rw, mr, mw, pe, pj, stw, saa, sr2, h, e};
  endfunction

  function automatic logic [11:0] snap();
    return {bus.imem_req, reg_write, bus.mem_read,
            bus.mem_write, pc_en, pc_sel_jump,
            sel_to_write, sel_alu_arg, sel_r2,
            halted, err};
  endfunction

  function automatic logic [11:0] fe();
    return mk(1, 0, 0, 0, 0, 0, 2'b00, 1, 1, 0, e_err);
  endfunction

  function automatic logic [11:0] idle();
    return mk(0, 0, 0, 0, 0, 0, 2'b00, 1, 1, 0, e_err);
  endfunction

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic push(input string t, input logic [11:0] s);
    exp_q.push_back(s);
    tag_q.push_back(t);
  endtask

  task automatic step(input logic ia, input logic ma,
                      input logic r);
    logic [11:0] e;
    string t;
    bus.imem_ack = ia;
    bus.mem_ack  = ma;
    rst          = r;
    #1;
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_bad++;
      $error("FAIL scoreboard_empty observed=%0h expected=none",
             snap());
    end else begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      check(t, 32'(snap()), 32'(e));
    end
    @(negedge clock);
  endtask

  // Pushes fetch/decode and the given exec snapshot, then runs 3 cycles.
  task automatic simple(input string t,
                        input logic [IW-1:0] ins,
                        input logic [11:0] ex);
    bus.instr = ins;
    push({t, "_fetch"}, fe());
    push({t, "_decode"}, idle());
    push({t, "_exec"}, ex);
    step(1, 0, 0);
    check({t, "_ir"}, 32'(ir), 32'(ins));
    step(1, 0, 0);
    step(1, 0, 0);
  endtask

  localparam logic [11:0] X_ALU_R =
    12'b0_1_0_0_1_0_00_1_1_0_0;
  localparam logic [11:0] X_ALU_I =
    12'b0_1_0_0_1_0_00_0_1_0_0;
  localparam logic [11:0] X_SHR =
    12'b0_1_0_0_1_0_01_1_1_0_0;
  localparam logic [11:0] X_JT =
    12'b0_0_0_0_1_1_00_1_1_0_0;
  localparam logic [11:0] X_JN =
    12'b0_0_0_0_1_0_00_1_1_0_0;

  initial begin
    rst = 1'b1;
    bus.imem_ack = 1'b0;
    bus.mem_ack  = 1'b0;
    bus.instr    = '0;
    alu_zero     = 1'b0;
    alu_carry    = 1'b0;
    @(negedge clock);
    #1;
    check("reset_strobes", 32'(snap()), 32'(fe()));
    check("reset_ir", 32'(ir), 32'(0));
    check("reset_flags", 32'({Zero, Carry}), 32'(0));
    @(negedge clock);
    rst = 1'b0;

    alu_zero = 1'b1; alu_carry = 1'b0;
    simple("alu_reg", {2'b00, 3'b010, 14'h0123}, X_ALU_R);
    check("alu_reg_fn", 32'(alu_fn), 32'(3'b010));
    check("alu_reg_flags", 32'({Zero, Carry}), 32'(2'b10));

    alu_zero = 1'b0; alu_carry = 1'b1;
    simple("alu_imm", {2'b01, 3'b101, 14'h0155}, X_ALU_I);
    check("alu_imm_flags", 32'({Zero, Carry}), 32'(2'b01));

    alu_zero = 1'b1; alu_carry = 1'b0;
    simple("shift", {3'b110, 2'b01, 14'h02AA}, X_SHR);
    check("shift_fn", 32'(shro_fn), 32'(2'b01));
    check("shift_flags", 32'({Zero, Carry}), 32'(2'b01));

    simple("bc_taken", {2'b10, 3'b110, 14'h0}, X_JT);
    simple("bz_not", {2'b10, 3'b101, 14'h0}, X_JN);

    alu_zero = 1'b1; alu_carry = 1'b0;
    simple("alu_z", {2'b00, 3'b000, 14'h0}, X_ALU_R);
    simple("bz_taken", {2'b10, 3'b101, 14'h0}, X_JT);
    simple("bc_not", {2'b10, 3'b110, 14'h0}, X_JN);
    simple("jmp", {2'b10, 3'b100, 14'h0}, X_JT);
    simple("nop", {2'b10, 3'b011, 14'h0}, X_JN);

    // LDM, ack 2 cycles late; stray ack in DECODE is ignored
    bus.instr = {2'b10, 3'b000, 14'h0};
    push("ldm_fetch", fe());
    push("ldm_decode", idle());
    push("ldm_exec", idle());
    for (int i = 0; i < 3; i++)
      push("ldm_mem", mk(0, 0, 1, 0, 0, 0, 2'b00, 1, 1, 0, 0));
    push("ldm_wb", mk(0, 1, 0, 0, 1, 0, 2'b10, 1, 1, 0, 0));
    step(1, 0, 0);
    step(0, 1, 0);
    step(0, 0, 0);
    step(0, 0, 0);
    step(0, 0, 0);
    step(0, 1, 0);
    step(0, 0, 0);

    bus.instr = {2'b10, 3'b001, 14'h0};
    push("stm_fetch", fe());
    push("stm_decode", idle());
    push("stm_exec", idle());
    push("stm_mem", mk(0, 0, 0, 1, 1, 0, 2'b00, 1, 0, 0, 0));
    step(1, 0, 0);
    step(0, 0, 0);
    step(0, 0, 0);
    step(0, 1, 0);

    push("stw_fetch", fe());
    push("stw_decode", idle());
    push("stw_exec", idle());
    for (int i = 0; i < 4; i++)
      push("stw_wait", mk(0, 0, 0, 1, 0, 0, 2'b00, 1, 0, 0, 0));
`ifdef CTRL_MEM_TIMEOUT_EN
    push("stw_abort", mk(0, 0, 0, 0, 1, 0, 2'b00, 1, 1, 0, 0));
    for (int i = 0; i < 8; i++)
      step(i == 0, 0, 0);
    e_err = 1'b1;
    check("timeout_err", 32'(err), 32'(1));
`else
    push("stw_wait", mk(0, 0, 0, 1, 0, 0, 2'b00, 1, 0, 0, 0));
    push("stw_ack", mk(0, 0, 0, 1, 1, 0, 2'b00, 1, 0, 0, 0));
    for (int i = 0; i < 8; i++)
      step(i == 0, 0, 0);
    step(0, 1, 0);
    check("no_timeout_err", 32'(err), 32'(0));
`endif

    // rst mid-MEM, together with an ack: rst wins, no pc_en
    push("str_fetch", fe());
    push("str_decode", idle());
    push("str_exec", idle());
    push("str_wait",
         mk(0, 0, 0, 1, 0, 0, 2'b00, 1, 0, 0, e_err));
    push("str_rst",
         mk(0, 0, 0, 1, 0, 0, 2'b00, 1, 0, 0, e_err));
    step(1, 0, 0);
    step(0, 0, 0);
    step(0, 0, 0);
    step(0, 0, 0);
    step(0, 1, 1);
    e_err = 1'b0;

    bus.instr = {3'b111, 2'b00, 14'h0};
    push("halt_after_rst", fe());
    push("halt_decode", idle());
    push("halt_exec", idle());
    for (int i = 0; i < 21; i++)
      push("halt_hold", mk(0, 0, 0, 0, 0, 0, 2'b00, 1, 1, 1, 0));
    push("halt_cleared", fe());
    step(1, 0, 0);
    check("halt_err_cleared", 32'(err), 32'(0));
    step(1, 1, 0);
    step(1, 1, 0);
    for (int i = 0; i < 20; i++)
      step(1, 1, 0);
    step(0, 0, 1);
    step(0, 0, 0);

    check("queue_drained", 32'(exp_q.size()), 32'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule
